// File: rtl/vend_dispenser_if.sv
// Signal bundle between the vending FSM / sensors and the dispenser mechanism controller.
// Latency: none (wires only).
// Backpressure: none; requests are strobes, overflow is reported through drop.
//
// Port summary:
//   out, change            : request strobes from the vending FSM
//   bottle_sense, coin_sense: synchronized mechanism sensor levels
//   fault_clr              : one-cycle fault acknowledge
//   motor_on, hopper_pulse : actuator drives
//   busy, fault, drop      : status
//   bottles_out, coins_out : delivery statistics
interface vend_dispenser_if;
  logic       out;
  logic [1:0] change;
  logic       bottle_sense;
  logic       coin_sense;
  logic       fault_clr;
  logic       motor_on;
  logic       hopper_pulse;
  logic       busy;
  logic       fault;
  logic       drop;
  logic [7:0] bottles_out;
  logic [7:0] coins_out;

  // Requester / sensor side.
  modport master (
    output out, change, bottle_sense, coin_sense, fault_clr,
    input  motor_on, hopper_pulse, busy, fault, drop, bottles_out, coins_out
  );

  // Dispenser side.
  modport slave (
    input  out, change, bottle_sense, coin_sense, fault_clr,
    output motor_on, hopper_pulse, busy, fault, drop, bottles_out, coins_out
  );
endinterface

// File: rtl/vend_dispenser.sv
// Bottle motor / 5 rs coin hopper controller with sensor confirmation, 1-deep pending slot and fault trap.
// Latency: request sampled in cycle N drives busy and the first actuator in cycle N+1; all outputs registered.
// Backpressure: none; a request with the slot full, during fault, or with change=11 is dropped and sets sticky drop.
//
// Ports: clk, rst (synchronous, active-high); bus (vend_dispenser_if.slave) carries requests,
// sensors, fault_clr, actuator drives, status and statistics.
// Optional build macro VEND_DISP_STATS_EN: when defined the bottles_out/coins_out counters are
// built; otherwise both ports are tied to 0.
module vend_dispenser #(
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic            clk,
  input logic            rst,
  vend_dispenser_if.slave bus
);

  // Timer is shared by the motor timeout, hopper pulse width and coin-wait timeout.
  localparam int unsigned CNT_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TW      = $clog2(CNT_MAX + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] P_LAST = TW'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND,
    S_COIN_PULSE,
    S_COIN_WAIT,
    S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    coins_q, coins_d;      // coins still owed for the job in service
  logic          latch_q, latch_d;      // coin_sense seen during the current pulse
  logic          slot_vld_q, slot_vld_d;
  logic          slot_bottle_q, slot_bottle_d;
  logic [1:0]    slot_coins_q, slot_coins_d;
  logic          drop_q, drop_d;
  logic          motor_q, hopper_q, busy_q, fault_q;

  logic req, req_bad, req_ok;
  logic complete, coin_done, enter;
  logic bot_inc, coin_inc;

  // The legal change codes 01/10 are numerically the coin count.
  assign req     = bus.out | (bus.change != 2'b00);
  assign req_bad = req & (bus.change == 2'b11);
  assign req_ok  = req & ~req_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      coins_q       <= '0;
      latch_q       <= 1'b0;
      slot_vld_q    <= 1'b0;
      slot_bottle_q <= 1'b0;
      slot_coins_q  <= '0;
      drop_q        <= 1'b0;
      motor_q       <= 1'b0;
      hopper_q      <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      coins_q       <= coins_d;
      latch_q       <= latch_d;
      slot_vld_q    <= slot_vld_d;
      slot_bottle_q <= slot_bottle_d;
      slot_coins_q  <= slot_coins_d;
      drop_q        <= drop_d;
      // Outputs are decoded from the next state so they line up with the state register.
      motor_q       <= (state_d == S_VEND);
      hopper_q      <= (state_d == S_COIN_PULSE);
      busy_q        <= (state_d != S_IDLE);
      fault_q       <= (state_d == S_FAULT);
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q + 1'b1;
    coins_d       = coins_q;
    latch_d       = latch_q;
    slot_vld_d    = slot_vld_q;
    slot_bottle_d = slot_bottle_q;
    slot_coins_d  = slot_coins_q;
    drop_d        = drop_q;
    complete      = 1'b0;
    coin_done     = 1'b0;
    enter         = 1'b0;
    bot_inc       = 1'b0;
    coin_inc      = 1'b0;

    if (req_bad) drop_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (req_ok) begin
          enter   = 1'b1;
          coins_d = bus.change;
          state_d = bus.out ? S_VEND : S_COIN_PULSE;
        end
      end
      S_VEND: begin
        if (bus.bottle_sense) begin
          bot_inc = 1'b1;
          if (coins_q != 2'd0) begin
            state_d = S_COIN_PULSE;
            enter   = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end else if (timer_q == T_LAST) begin
          state_d = S_FAULT;
          enter   = 1'b1;
        end
      end
      S_COIN_PULSE: begin
        if (bus.coin_sense) latch_d = 1'b1;
        if (timer_q == P_LAST) begin
          // A sense in the final pulse cycle counts as seen during the pulse.
          if (latch_q | bus.coin_sense) begin
            coin_done = 1'b1;
          end else begin
            state_d = S_COIN_WAIT;
            enter   = 1'b1;
          end
        end
      end
      S_COIN_WAIT: begin
        if (bus.coin_sense) begin
          coin_done = 1'b1;
        end else if (timer_q == T_LAST) begin
          state_d = S_FAULT;
          enter   = 1'b1;
        end
      end
      S_FAULT: begin
        timer_d = '0;
        if (req) drop_d = 1'b1;
        if (bus.fault_clr) begin
          state_d = S_IDLE;
          enter   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        enter   = 1'b1;
      end
    endcase

    if (coin_done) begin
      coin_inc = 1'b1;
      coins_d  = coins_q - 2'd1;
      if (coins_q != 2'd1) begin
        state_d = S_COIN_PULSE;   // re-entry restarts the pulse timer
        enter   = 1'b1;
      end else begin
        complete = 1'b1;
      end
    end

    // Pending slot while a job is in service. On completion the slot (or, if empty,
    // a request arriving this very cycle) is started without an IDLE cycle.
    if (state_q inside {S_VEND, S_COIN_PULSE, S_COIN_WAIT}) begin
      if (complete) begin
        enter = 1'b1;
        if (slot_vld_q) begin
          state_d       = slot_bottle_q ? S_VEND : S_COIN_PULSE;
          coins_d       = slot_coins_q;
          slot_vld_d    = req_ok;
          slot_bottle_d = bus.out;
          slot_coins_d  = bus.change;
        end else if (req_ok) begin
          state_d = bus.out ? S_VEND : S_COIN_PULSE;
          coins_d = bus.change;
        end else begin
          state_d = S_IDLE;
        end
      end else if (req_ok) begin
        if (slot_vld_q) begin
          drop_d = 1'b1;
        end else begin
          slot_vld_d    = 1'b1;
          slot_bottle_d = bus.out;
          slot_coins_d  = bus.change;
        end
      end
    end

    if (state_d == S_FAULT) slot_vld_d = 1'b0;

    if (enter) begin
      timer_d = '0;
      latch_d = 1'b0;
    end
  end

  assign bus.motor_on     = motor_q;
  assign bus.hopper_pulse = hopper_q;
  assign bus.busy         = busy_q;
  assign bus.fault        = fault_q;
  assign bus.drop         = drop_q;

`ifdef VEND_DISP_STATS_EN
  logic [7:0] bottles_q, coins_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bottles_q   <= '0;
      coins_out_q <= '0;
    end else begin
      if (bot_inc)  bottles_q   <= bottles_q + 8'd1;
      if (coin_inc) coins_out_q <= coins_out_q + 8'd1;
    end
  end

  assign bus.bottles_out = bottles_q;
  assign bus.coins_out   = coins_out_q;
`else
  logic unused_stats;
  assign unused_stats    = bot_inc ^ coin_inc;
  assign bus.bottles_out = '0;
  assign bus.coins_out   = '0;
`endif

endmodule

// File: tb/tb_vend_dispenser.sv
// Testbench for vend_dispenser: directed scenarios plus randomized traffic against a job-queue reference model.
// Latency: checks every output one cycle after each input cycle.
// Backpressure: n/a.
module tb_vend_dispenser;
  localparam int unsigned PULSE = 4;
  localparam int unsigned TMO   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vend_dispenser_if vif();

  vend_dispenser #(
    .PULSE_CYCLES  (PULSE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Jobs waiting or in service live in a queue; jobs[0] is the one the mechanism works on.
  typedef struct {
    bit bottle;
    int coins;
  } job_t;

  localparam int MECH_REST   = 0;  // nothing to do
  localparam int MECH_MOTOR  = 1;  // waiting for a bottle to drop
  localparam int MECH_PULSE  = 2;  // hopper solenoid firing
  localparam int MECH_LISTEN = 3;  // pulse over, listening for the coin
  localparam int MECH_STUCK  = 4;  // mechanism timed out

  job_t       jobs[$];
  int         mech;
  int         elapsed;
  bit         coin_seen;
  bit         m_drop;
  logic [7:0] m_bottles;
  logic [7:0] m_coins;

  task automatic model_reset();
    jobs.delete();
    mech      = MECH_REST;
    elapsed   = 0;
    coin_seen = 0;
    m_drop    = 0;
    m_bottles = 0;
    m_coins   = 0;
  endtask

  task automatic start_head();
    mech      = jobs[0].bottle ? MECH_MOTOR : MECH_PULSE;
    elapsed   = 0;
    coin_seen = 0;
  endtask

  task automatic model_step(input bit o, input logic [1:0] ch, input bit bs, input bit cs, input bit fc);
    bit   req, legal, finished, trapped, coin_given;
    job_t j;
    req        = o || (ch != 2'b00);
    legal      = req && (ch != 2'b11);
    finished   = 0;
    trapped    = 0;
    coin_given = 0;
    j.bottle   = o;
    j.coins    = int'(ch);
    if (req && !legal) m_drop = 1;
    if (mech == MECH_REST) begin
      if (legal) begin
        jobs.push_back(j);
        start_head();
      end
    end else if (mech == MECH_STUCK) begin
      if (req) m_drop = 1;
      if (fc) mech = MECH_REST;
    end else begin
      if (mech == MECH_MOTOR) begin
        if (bs) begin
          m_bottles++;
          if (jobs[0].coins > 0) begin
            mech = MECH_PULSE; elapsed = 0; coin_seen = 0;
          end else finished = 1;
        end else begin
          elapsed++;
          if (elapsed >= TMO) trapped = 1;
        end
      end else if (mech == MECH_PULSE) begin
        if (cs) coin_seen = 1;
        elapsed++;
        if (elapsed == PULSE) begin
          if (coin_seen) coin_given = 1;
          else begin mech = MECH_LISTEN; elapsed = 0; end
        end
      end else begin
        if (cs) coin_given = 1;
        else begin
          elapsed++;
          if (elapsed >= TMO) trapped = 1;
        end
      end
      if (coin_given) begin
        m_coins++;
        jobs[0].coins--;
        if (jobs[0].coins > 0) begin
          mech = MECH_PULSE; elapsed = 0; coin_seen = 0;
        end else finished = 1;
      end
      if (finished) void'(jobs.pop_front());
      if (legal) begin
        if (jobs.size() < 2) jobs.push_back(j);
        else m_drop = 1;
      end
      if (trapped) begin
        jobs.delete();
        mech = MECH_STUCK;
      end else if (finished) begin
        if (jobs.size() > 0) start_head();
        else mech = MECH_REST;
      end
    end
  endtask

  task automatic compare_all();
    chk("motor_on",     vif.motor_on,     mech == MECH_MOTOR);
    chk("hopper_pulse", vif.hopper_pulse, mech == MECH_PULSE);
    chk("busy",         vif.busy,         mech != MECH_REST);
    chk("fault",        vif.fault,        mech == MECH_STUCK);
    chk("drop",         vif.drop,         m_drop);
`ifdef VEND_DISP_STATS_EN
    chk("bottles_out",  vif.bottles_out,  m_bottles);
    chk("coins_out",    vif.coins_out,    m_coins);
`else
    chk("bottles_out",  vif.bottles_out,  0);
    chk("coins_out",    vif.coins_out,    0);
`endif
  endtask

  // One input cycle: drive, let the DUT and model step at the edge, then compare.
  task automatic tick(input bit r, input bit o, input logic [1:0] ch, input bit bs, input bit cs, input bit fc);
    rst              = r;
    vif.out          = o;
    vif.change       = ch;
    vif.bottle_sense = bs;
    vif.coin_sense   = cs;
    vif.fault_clr    = fc;
    @(posedge clk);
    if (r) model_reset();
    else   model_step(o, ch, bs, cs, fc);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic do_reset();
    tick(1, 0, 2'b00, 0, 0, 0);
    tick(1, 0, 2'b00, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("reset_busy", vif.busy, 0);

    // Bottle only, sensed in cycle 5.
    tick(0, 1, 2'b00, 0, 0, 0);
    chk("s1_motor_c1", vif.motor_on, 1);
    idle(4);
    tick(0, 0, 2'b00, 1, 0, 0);
    chk("s1_busy_c6", vif.busy, 0);
    chk("s1_motor_c6", vif.motor_on, 0);
`ifdef VEND_DISP_STATS_EN
    chk("s1_bottles", vif.bottles_out, 1);
`endif

    // Two coins, first needs COIN_WAIT, sensed at 7 and 13.
    do_reset();
    tick(0, 0, 2'b10, 0, 0, 0);
    chk("s2_hopper_c1", vif.hopper_pulse, 1);
    idle(3);
    chk("s2_hopper_c4", vif.hopper_pulse, 1);
    idle(3);
    chk("s2_hopper_c7", vif.hopper_pulse, 0);
    tick(0, 0, 2'b00, 0, 1, 0);
    chk("s2_hopper_c8", vif.hopper_pulse, 1);
    idle(5);
    tick(0, 0, 2'b00, 0, 1, 0);
    chk("s2_busy_c14", vif.busy, 0);
`ifdef VEND_DISP_STATS_EN
    chk("s2_coins", vif.coins_out, 2);
`endif

    // Back-to-back requests: second queued, third dropped.
    do_reset();
    tick(0, 1, 2'b01, 0, 0, 0);
    idle(1);
    tick(0, 0, 2'b01, 0, 0, 0);
    chk("s3_drop_c3", vif.drop, 0);
    tick(0, 0, 2'b01, 0, 0, 0);
    chk("s3_drop_c4", vif.drop, 1);
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 2'b00, 1, 1, 0);
    end
    chk("s3_busy_done", vif.busy, 0);

    // Motor timeout, request during fault, fault clear at 20.
    do_reset();
    tick(0, 1, 2'b00, 0, 0, 0);
    idle(15);
    chk("s4_motor_c16", vif.motor_on, 1);
    chk("s4_fault_c16", vif.fault, 0);
    idle(1);
    chk("s4_fault_c17", vif.fault, 1);
    chk("s4_motor_c17", vif.motor_on, 0);
    tick(0, 1, 2'b00, 0, 0, 0);
    chk("s4_drop_c18", vif.drop, 1);
    idle(2);
    tick(0, 0, 2'b00, 0, 0, 1);
    chk("s4_fault_c21", vif.fault, 0);
    chk("s4_busy_c21", vif.busy, 0);

    // Illegal change code, then reset in the middle of a pulse.
    do_reset();
    tick(0, 1, 2'b11, 0, 0, 0);
    chk("s5_motor", vif.motor_on, 0);
    chk("s5_drop", vif.drop, 1);
    tick(0, 0, 2'b01, 0, 0, 0);
    tick(0, 0, 2'b00, 0, 0, 0);
    chk("s5_hopper", vif.hopper_pulse, 1);
    tick(1, 0, 2'b00, 0, 0, 0);
    chk("s5_rst_hopper", vif.hopper_pulse, 0);
    chk("s5_rst_drop", vif.drop, 0);
    chk("s5_rst_busy", vif.busy, 0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      bit         r, o, bs, cs, fc;
      logic [1:0] ch;
      r  = ($urandom_range(0, 499) == 0);
      o  = 0;
      ch = 2'b00;
      if ($urandom_range(0, 4) == 0) begin
        o = $urandom_range(0, 1);
        if ($urandom_range(0, 9) == 0) ch = 2'b11;
        else ch = 2'($urandom_range(0, 2));
      end
      bs = ($urandom_range(0, 7) == 0);
      cs = ($urandom_range(0, 7) == 0);
      fc = ($urandom_range(0, 5) == 0);
      tick(r, o, ch, bs, cs, fc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
